// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner for the multicycle core; fetches over a variable-latency
// req/valid handshake with timeout, and decodes IR fields and the sign-extended immediate.
module instr_fetch_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT_CYC = 255,
    parameter int              CNT_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_ir_i,
    input  logic            pc_write_i,
    input  logic            pc_write_beq_i,
    input  logic            pc_write_bne_i,
    input  logic            pc_source_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic            alu_zero_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_valid_i,
    output logic            fetch_busy_o,
    output logic            fetch_err_o,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [4:0]      rd_o,
    output logic [2:0]      func3_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [6:0]      func7_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic {IDLE, REQ} state_t;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     ir_q, ir_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            start, timeout, pc_en;
    assign start   = state_q == IDLE && load_ir_i && pc_write_i;
    assign timeout = state_q == REQ && cnt_q == CNT_W'(TIMEOUT_CYC);
    // Handshake outputs are gated by reset so they drop in the same cycle reset asserts.
    assign imem_req_o   = !reset && (start || state_q == REQ);
    assign fetch_busy_o = !reset && !imem_valid_i && (start || (state_q == REQ && !timeout));
    assign pc_en = !fetch_busy_o && (pc_write_i || (pc_write_beq_i && alu_zero_i) ||
                                     (pc_write_bne_i && !alu_zero_i));
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        err_d   = err_q;
        pc_d    = pc_en ? (pc_source_i ? alu_out_i : alu_result_i) : pc_q;
        if (start) begin
            if (imem_valid_i) ir_d = imem_rdata_i;
            else begin
                state_d = REQ;
                cnt_d   = CNT_W'(1);
            end
        end else if (state_q == REQ) begin
            if (imem_valid_i) begin
                ir_d    = imem_rdata_i;
                state_d = IDLE;
            end else if (timeout) begin
                ir_d    = NOP;
                err_d   = 1'b1;
                state_d = IDLE;
            end else cnt_d = cnt_q + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ir_q    <= NOP;
            err_q   <= 1'b0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
        end
    end
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign fetch_err_o = err_q;
    assign opcode_o    = ir_q[6:0];
    assign rd_o        = ir_q[11:7];
    assign func3_o     = ir_q[14:12];
    assign rs1_o       = ir_q[19:15];
    assign rs2_o       = ir_q[24:20];
    assign func7_o     = ir_q[31:25];
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
    always_comb begin
        illegal_o = !(opcode_o inside {7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h33});
        imm_o = (opcode_o == 7'h13 || opcode_o == 7'h03) ? imm_i :
                (opcode_o == 7'h23)                       ? imm_s :
                (opcode_o == 7'h63 || opcode_o == 7'h67) ? imm_b :
                (opcode_o == 7'h37)                       ? imm_u : '0;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized fetch/branch traffic checked
// against a transaction-level model of PC, IR, error flag and busy duration.
module tb_instr_fetch_unit;
    localparam int TO = 255;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic reset;
    logic load_ir, pc_write, pc_write_beq, pc_write_bne, pc_source, alu_zero;
    logic [63:0] alu_result, alu_out;
    logic imem_req, imem_valid, fetch_busy, fetch_err, illegal;
    logic [63:0] imem_addr, pc, imm;
    logic [31:0] imem_rdata;
    logic [6:0] opcode, func7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] func3;
    always #5 clk = ~clk;
    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .load_ir_i(load_ir), .pc_write_i(pc_write),
        .pc_write_beq_i(pc_write_beq), .pc_write_bne_i(pc_write_bne), .pc_source_i(pc_source),
        .alu_result_i(alu_result), .alu_out_i(alu_out), .alu_zero_i(alu_zero),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .imem_valid_i(imem_valid), .fetch_busy_o(fetch_busy), .fetch_err_o(fetch_err),
        .pc_o(pc), .opcode_o(opcode), .rd_o(rd), .func3_o(func3), .rs1_o(rs1), .rs2_o(rs2),
        .func7_o(func7), .imm_o(imm), .illegal_o(illegal)
    );
    int n_tests = 0, n_fail = 0;
    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic m_err;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint s;
        int op;
        s = $signed(w);
        op = int'(w & 32'h7f);
        if (op == 'h13 || op == 'h03) return s >>> 20;
        if (op == 'h23) return ((s >>> 25) <<< 5) | ((s >> 7) & 31);
        if (op == 'h63 || op == 'h67)
            return ((s >>> 31) <<< 12) | (((s >> 7) & 1) << 11) | (((s >> 25) & 63) << 5) |
                   (((s >> 8) & 15) << 1);
        if (op == 'h37) return s & ~64'hfff;
        return 0;
    endfunction
    function automatic logic ref_illegal(input logic [31:0] w);
        int op;
        op = int'(w & 32'h7f);
        return !(op == 'h13 || op == 'h03 || op == 'h23 || op == 'h63 || op == 'h67 ||
                 op == 'h37 || op == 'h33);
    endfunction
    task automatic check_state(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".opcode"}, 64'(opcode), 64'(m_ir % 128));
        chk({tag, ".rd"}, 64'(rd), 64'((m_ir / 128) % 32));
        chk({tag, ".func3"}, 64'(func3), 64'((m_ir / 4096) % 8));
        chk({tag, ".rs1"}, 64'(rs1), 64'((m_ir / 32768) % 32));
        chk({tag, ".rs2"}, 64'(rs2), 64'((m_ir / 1048576) % 32));
        chk({tag, ".func7"}, 64'(func7), 64'(m_ir / 33554432));
        chk({tag, ".imm"}, imm, ref_imm(m_ir));
        chk({tag, ".illegal"}, 64'(illegal), 64'(ref_illegal(m_ir)));
        chk({tag, ".err"}, 64'(fetch_err), 64'(m_err));
        chk({tag, ".busy"}, 64'(fetch_busy), 64'(0));
        chk({tag, ".req"}, 64'(imem_req), 64'(0));
    endtask
    task automatic clear_inputs();
        load_ir = 0; pc_write = 0; pc_write_beq = 0; pc_write_bne = 0; pc_source = 0;
        alu_zero = 0; imem_valid = 0; imem_rdata = $urandom;
        alu_result = {$urandom, $urandom}; alu_out = {$urandom, $urandom};
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        m_pc = 0; m_ir = NOP; m_err = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        #1 check_state("reset");
    endtask
    // One fetch whose data arrives lat cycles after the start cycle (lat > TO never arrives).
    task automatic fetch(input logic [31:0] word, input int lat, input logic src,
                         input logic [63:0] res, input logic [63:0] out);
        int busy_cnt = 0;
        logic done = 0;
        @(negedge clk);
        load_ir = 1; pc_write = 1; pc_source = src; alu_result = res; alu_out = out;
        for (int c = 0; c <= TO + 5 && !done; c++) begin
            imem_valid = (c == lat);
            imem_rdata = (c == lat) ? word : $urandom;
            #1;
            chk("fetch.req", 64'(imem_req), 64'(1));
            chk("fetch.addr", imem_addr, m_pc);
            if (fetch_busy) busy_cnt++; else done = 1;
            if (!done) @(negedge clk);
        end
        chk("fetch.busy_cycles", 64'(busy_cnt), 64'(lat < TO ? lat : TO));
        m_ir = (lat > TO) ? NOP : word;
        if (lat > TO) m_err = 1;
        m_pc = src ? out : res;
        @(negedge clk);
        clear_inputs();
        #1 check_state("fetch");
    endtask
    task automatic branch(input logic beq, input logic bne, input logic zero, input logic src,
                          input logic [63:0] res, input logic [63:0] out);
        @(negedge clk);
        pc_write_beq = beq; pc_write_bne = bne; alu_zero = zero; pc_source = src;
        alu_result = res; alu_out = out; imem_valid = $urandom_range(0, 1);
        #1 chk("branch.req", 64'(imem_req), 64'(0));
        if ((beq && zero) || (bne && !zero)) m_pc = src ? out : res;
        @(negedge clk);
        clear_inputs();
        #1 check_state("branch");
    endtask
    task automatic hold_ir();
        @(negedge clk);
        load_ir = 1; imem_valid = 1; imem_rdata = $urandom;
        #1 chk("hold.req", 64'(imem_req), 64'(0));
        chk("hold.busy", 64'(fetch_busy), 64'(0));
        @(negedge clk);
        clear_inputs();
        #1 check_state("hold");
    endtask
    function automatic logic [31:0] rand_word();
        logic [6:0] ops [8] = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h33, 7'h7f};
        logic [31:0] w;
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 7)];
        return w;
    endfunction
    initial begin
        reset = 1;
        clear_inputs();
        do_reset();
        fetch(32'h00A0_0093, 0, 0, 64'd4, 64'd0);
        chk("t1.imm", imm, 64'd10);
        chk("t1.rd", 64'(rd), 64'd1);
        chk("t1.pc", pc, 64'd4);
        fetch(32'h0010_0113, 3, 0, 64'd8, 64'hdead);
        fetch(32'hFE20_8EE3, 0, 0, 64'd8, 64'd0);
        chk("t3.imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        branch(1, 0, 1, 1, 64'd0, 64'h10);
        chk("t3.beq_taken", pc, 64'h10);
        branch(1, 0, 0, 1, 64'd0, 64'h30);
        branch(0, 1, 0, 1, 64'd0, 64'h20);
        chk("t3.bne_taken", pc, 64'h20);
        branch(0, 1, 1, 1, 64'd0, 64'h40);
        fetch(32'h1234_50B7, 1, 1, 64'd0, 64'h24);
        chk("t6.lui", imm, 64'h1234_5000);
        fetch(32'hFFF0_0013, 2, 0, 64'h28, 64'd0);
        chk("t6.neg1", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        fetch(32'h0000_007F, 0, 0, 64'h2c, 64'd0);
        chk("t6.illegal", 64'(illegal), 64'd1);
        hold_ir();
        fetch(32'h0040_0193, TO, 0, 64'h30, 64'd0);
        chk("t4.edge_noerr", 64'(fetch_err), 64'd0);
        fetch(32'h0050_0213, TO + 10, 0, 64'h34, 64'd0);
        chk("t4.timeout_err", 64'(fetch_err), 64'd1);
        fetch(32'h0060_0293, 1, 0, 64'h38, 64'd0);
        chk("t4.sticky", 64'(fetch_err), 64'd1);
        @(negedge clk);
        load_ir = 1; pc_write = 1; alu_result = 64'h99;
        repeat (3) @(negedge clk);
        #1 chk("t5.busy_before", 64'(fetch_busy), 64'd1);
        reset = 1;
        #1 chk("t5.req_reset", 64'(imem_req), 64'd0);
        chk("t5.busy_reset", 64'(fetch_busy), 64'd0);
        chk("t5.pc_reset", pc, 64'd0);
        do_reset();
        hold_ir();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1: branch($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                             $urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom});
                2: hold_ir();
                default: fetch(rand_word(), $urandom_range(0, 6), $urandom_range(0, 1),
                               {$urandom, $urandom}, {$urandom, $urandom});
            endcase
        end
        fetch(rand_word(), TO + 1, 1, 64'h0, 64'h1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
